uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 4..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ena  input  1  hold: while 1, receiver aborts any frame and stays in IDLE.
REQ-005 SHALL have port in  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rd  input  1  consumer acknowledge, clears ready and overrun.
REQ-007 SHALL have port data  output  8  last correctly framed byte.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when data is updated.
REQ-009 SHALL have port ready  output  1  byte waiting; set with valid, cleared by rd.
REQ-010 SHALL have port overrun  output  1  sticky; a byte was overwritten while ready=1.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-012 SHALL have port bussy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL pass in through a 2-flop synchronizer; all decisions use the second flop (rx_s); it adds 2 cycles of latency.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK, with a baud counter (8 bits) and a bit index (3 bits).
REQ-015 IDLE: when rx_s=0, go to START with the baud counter cleared.
REQ-016 START: when the baud counter reaches CLKS_PER_BIT/2-1 (integer division), sample rx_s. If 0, go to DATA with the counter and bit index cleared. If 1, treat as a glitch and return to IDLE with no flag.
REQ-017 DATA: when the baud counter reaches CLKS_PER_BIT-1, sample rx_s into shift bit [index], clear the counter and increment the index. After index 7 is sampled, go to STOP.
REQ-018 STOP: when the baud counter reaches CLKS_PER_BIT-1, sample rx_s. If 1, go to IDLE. If 0, go to BREAK.
REQ-019 A good stop bit SHALL, in the same edge: load data from the shift register, set ready=1, and pulse valid=1 for exactly one cycle.
REQ-020 A bad stop bit SHALL pulse frame_err for one cycle and leave data, ready and valid unchanged.
REQ-021 BREAK: remain until rx_s=1, then go to IDLE; a line held low SHALL NOT produce repeated frames or errors.
REQ-022 Overrun: if a good frame completes while ready=1 and rd=0, set overrun=1 and overwrite data.
REQ-023 rd=1 SHALL clear ready and overrun on the next edge; rd when ready=0 has no effect.
REQ-024 rd=1 in the same cycle as a good frame completion: the new byte wins (ready stays 1, valid pulses) and overrun is not set.
REQ-025 ena=1 SHALL synchronously force IDLE, clear the counters and shift register, and emit no pulses; data, ready and overrun are retained.
REQ-026 Mid-frame sample decisions SHALL be taken only at the defined counter values; the line level between samples is ignored.
REQ-027 Back-to-back frames: a start bit arriving in the first IDLE cycle after STOP SHALL be accepted.

Reset
REQ-028 While reset=0, immediately: state=IDLE, counters=0, shift=0, data=8'h00, valid=0, ready=0, overrun=0, frame_err=0, bussy=0, synchronizer flops=1.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte. After release, the receiver SHALL wait for a fresh falling edge on rx_s.

Verification
REQ-030 CLKS_PER_BIT=16, send 8'hA5 (8N1) -> valid pulses once, data=8'hA5, ready=1, frame_err=0, bussy=0 afterwards.
REQ-031 Low pulse of 5 cycles on in while IDLE -> returns to IDLE after start-bit check, no valid, no frame_err.
REQ-032 Send 8'h3C with the stop bit forced low, then hold the line low 64 cycles -> a single frame_err pulse, data unchanged, bussy=1 until the line goes high.
REQ-033 Send 8'h11 then 8'h22 without rd -> overrun=1, data=8'h22; rd=1 -> ready=0 and overrun=0 next cycle.
REQ-034 rd asserted on the exact cycle 8'h55 completes with ready=1 -> ready=1, overrun=0, data=8'h55.
REQ-035 reset=0 at bit 4 of a frame, then released and 8'h0F sent -> outputs at reset values, then data=8'h0F. Repeat the scenario with ena=1 instead of reset -> no pulses, prior data retained.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, latched byte with ready/overrun.
// A byte lands 2 + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start edge; no backpressure, rd only acknowledges.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       in,
    input  logic       rd,
    output logic [7:0] data,
    output logic       valid,
    output logic       ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       bussy
);

    localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] FULL_M1 = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, ready_q, ready_d, ovr_q, ovr_d, ferr_q;
    logic        rx_meta_q, rx_s_q;
    logic        good, bad;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        good    = 1'b0;
        bad     = 1'b0;
        if (ena) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rx_s_q) state_d = START;
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        shift_d[idx_q] = rx_s_q;
                        cnt_d          = '0;
                        idx_d          = idx_q + 3'd1;
                        if (idx_q == 3'd7) state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_d = '0;
                        if (rx_s_q) begin
                            state_d = IDLE;
                            good    = 1'b1;
                        end else begin
                            state_d = BRK;
                            bad     = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                BRK: begin
                    // Stay parked until the line recovers so a held-low line reports once.
                    if (rx_s_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A completing frame beats a simultaneous rd: the fresh byte must not be lost.
    always_comb begin
        data_d  = good ? shift_q : data_q;
        ready_d = good ? 1'b1 : (rd ? 1'b0 : ready_q);
        if (good && ready_q && !rd) ovr_d = 1'b1;
        else if (rd)                ovr_d = 1'b0;
        else                        ovr_d = ovr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= in;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= good;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            ferr_q    <= bad;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign ready     = ready_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;
    assign bussy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: scenario tasks driving 8N1 frames, checked against a byte-level model.
module tb_uart_rx;

    localparam int C   = 16;
    localparam int H   = C / 2;
    // start edge -> 2 sync flops -> IDLE sees low -> half bit -> 8 data bits + stop bit
    localparam int LAT = 3 + H + 9 * C;

    logic       clk = 1'b0;
    logic       reset, ena, in, rd;
    logic [7:0] data;
    logic       valid, ready, overrun, frame_err, bussy;

    int checks = 0;
    int failures = 0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .ena(ena), .in(in), .rd(rd),
        .data(data), .valid(valid), .ready(ready), .overrun(overrun),
        .frame_err(frame_err), .bussy(bussy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vcnt = 0;
    int         fcnt = 0;
    logic [7:0] vq_dat[$];
    int         vq_cyc[$];
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcnt <= vcnt + 1;
            vq_dat.push_back(data);
            vq_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) fcnt <= fcnt + 1;
    end

    // Byte-level model of the consumer-visible state.
    logic [7:0] m_data = 8'h00;
    bit         m_ready = 1'b0;
    bit         m_ovr = 1'b0;
    int         tx_start = 0;

    task automatic model_frame(input logic [7:0] b, input bit rd_same);
        if (m_ready && !rd_same) m_ovr = 1'b1;
        m_ready = 1'b1;
        m_data  = b;
    endtask

    task automatic model_rd();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Drive one frame from a negedge; ncyc >= 0 truncates it, rd_off pulses rd at that cycle.
    task automatic tx(input logic [7:0] b, input logic stop_v, input int stop_len,
                      input int rd_off, input int ncyc, input bit noise);
        int   total;
        int   bi;
        int   off;
        logic v;
        total = 9 * C + stop_len;
        if (ncyc >= 0 && ncyc < total) total = ncyc;
        tx_start = cyc;
        for (int t = 0; t < total; t++) begin
            bi  = t / C;
            off = t % C;
            if (bi == 0)      v = 1'b0;
            else if (bi <= 8) v = b[bi-1];
            else              v = stop_v;
            if (noise && bi >= 1 && bi <= 8 && (off < 3 || off > C - 4)) v = ~v;
            in = v;
            rd = (t == rd_off);
            @(negedge clk);
        end
        rd = 1'b0;
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; ena = 1'b0; in = 1'b1; rd = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (bussy !== 1'b0) begin failures++; $display("FAIL reset_bussy got=%b exp=0", bussy); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bussy !== 1'b0) begin failures++; $display("FAIL reset_release_bussy got=%b exp=0", bussy); end
    endtask

    task automatic test_basic();
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        tx(8'hA5, 1'b1, C, -1, -1, 1'b0);
        in = 1'b1;
        repeat (4) @(negedge clk);
        model_frame(8'hA5, 1'b0);
        checks++; if (vcnt - v0 != 1) begin failures++; $display("FAIL basic_valid_count got=%0d exp=1", vcnt - v0); end
        checks++; if (data !== m_data) begin failures++; $display("FAIL basic_data got=%h exp=%h", data, m_data); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", ready); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%b exp=0", overrun); end
        checks++; if (fcnt != f0) begin failures++; $display("FAIL basic_frame_err got=%0d exp=0", fcnt - f0); end
        checks++; if (bussy !== 1'b0) begin failures++; $display("FAIL basic_bussy got=%b exp=0", bussy); end
        checks++; if (vq_cyc[vq_cyc.size()-1] - tx_start != LAT)
            begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", vq_cyc[vq_cyc.size()-1] - tx_start, LAT); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        in = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bussy !== 1'b1) begin failures++; $display("FAIL glitch_start_bussy got=%b exp=1", bussy); end
        in = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (vcnt != v0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", vcnt - v0); end
        checks++; if (fcnt != f0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fcnt - f0); end
        checks++; if (bussy !== 1'b0) begin failures++; $display("FAIL glitch_bussy got=%b exp=0", bussy); end
        checks++; if (data !== m_data) begin failures++; $display("FAIL glitch_data got=%h exp=%h", data, m_data); end
    endtask

    task automatic test_break();
        int v0, f0;
        v0 = vcnt; f0 = fcnt;
        tx(8'h3C, 1'b0, C + 64, -1, -1, 1'b0);
        checks++; if (bussy !== 1'b1) begin failures++; $display("FAIL break_bussy_low got=%b exp=1", bussy); end
        checks++; if (fcnt - f0 != 1) begin failures++; $display("FAIL break_frame_err_count got=%0d exp=1", fcnt - f0); end
        checks++; if (vcnt != v0) begin failures++; $display("FAIL break_valid got=%0d exp=0", vcnt - v0); end
        checks++; if (data !== m_data) begin failures++; $display("FAIL break_data got=%h exp=%h", data, m_data); end
        checks++; if (ready !== m_ready) begin failures++; $display("FAIL break_ready got=%b exp=%b", ready, m_ready); end
        in = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (bussy !== 1'b0) begin failures++; $display("FAIL break_bussy_high got=%b exp=0", bussy); end
        checks++; if (fcnt - f0 != 1) begin failures++; $display("FAIL break_frame_err_final got=%0d exp=1", fcnt - f0); end
    endtask

    task automatic test_overrun();
        pulse_rd(); model_rd();
        tx(8'h11, 1'b1, C, -1, -1, 1'b0); model_frame(8'h11, 1'b0);
        tx(8'h22, 1'b1, C, -1, -1, 1'b0); model_frame(8'h22, 1'b0);
        in = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL ovr_flag got=%b exp=%b", overrun, m_ovr); end
        checks++; if (data !== m_data) begin failures++; $display("FAIL ovr_data got=%h exp=%h", data, m_data); end
        checks++; if (ready !== m_ready) begin failures++; $display("FAIL ovr_ready got=%b exp=%b", ready, m_ready); end
        pulse_rd(); model_rd();
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ovr_rd_ready got=%b exp=0", ready); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_rd_overrun got=%b exp=0", overrun); end
        pulse_rd();
        checks++; if (data !== m_data || ready !== 1'b0)
            begin failures++; $display("FAIL ovr_idle_rd got=%h/%b exp=%h/0", data, ready, m_data); end
    endtask

    task automatic test_rd_same_cycle();
        logic [7:0] b;
        int v0;
        v0 = vcnt;
        b = 8'($urandom);
        tx(b, 1'b1, C, -1, -1, 1'b0); model_frame(b, 1'b0);
        tx(8'h55, 1'b1, C, LAT - 1, -1, 1'b0); model_frame(8'h55, 1'b1);
        in = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL same_ready got=%b exp=1", ready); end
        checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL same_overrun got=%b exp=%b", overrun, m_ovr); end
        checks++; if (data !== m_data) begin failures++; $display("FAIL same_data got=%h exp=%h", data, m_data); end
        checks++; if (vcnt - v0 != 2) begin failures++; $display("FAIL same_valid_count got=%0d exp=2", vcnt - v0); end
    endtask

    task automatic test_reset_midframe();
        int v0, f0;
        tx(8'($urandom), 1'b1, C, -1, 5 * C + H, 1'b0);
        reset = 1'b0;
        in = 1'b1;
        #1;
        m_data = 8'h00; m_ready = 1'b0; m_ovr = 1'b0;
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", ready); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
        checks++; if (bussy !== 1'b0) begin failures++; $display("FAIL rstmid_bussy got=%b exp=0", bussy); end
        checks++; if (valid !== 1'b0 || frame_err !== 1'b0)
            begin failures++; $display("FAIL rstmid_pulses got=%b%b exp=00", valid, frame_err); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        v0 = vcnt; f0 = fcnt;
        checks++; if (bussy !== 1'b0) begin failures++; $display("FAIL rstmid_release_bussy got=%b exp=0", bussy); end
        tx(8'h0F, 1'b1, C, -1, -1, 1'b0); model_frame(8'h0F, 1'b0);
        in = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (data !== m_data) begin failures++; $display("FAIL rstmid_new_data got=%h exp=%h", data, m_data); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rstmid_new_ready got=%b exp=1", ready); end
        checks++; if (vcnt - v0 != 1 || fcnt != f0)
            begin failures++; $display("FAIL rstmid_new_pulses got=%0d/%0d exp=1/0", vcnt - v0, fcnt - f0); end
    endtask

    task automatic test_ena_abort();
        int v0, f0;
        logic [7:0] b;
        v0 = vcnt; f0 = fcnt;
        tx(8'($urandom), 1'b1, C, -1, 5 * C + H, 1'b0);
        ena = 1'b1;
        @(negedge clk);
        checks++; if (bussy !== 1'b0) begin failures++; $display("FAIL ena_bussy got=%b exp=0", bussy); end
        in = 1'b0;
        repeat (2 * C) @(negedge clk);
        checks++; if (bussy !== 1'b0) begin failures++; $display("FAIL ena_hold_bussy got=%b exp=0", bussy); end
        in = 1'b1;
        repeat (4) @(negedge clk);
        ena = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (vcnt != v0 || fcnt != f0)
            begin failures++; $display("FAIL ena_pulses got=%0d/%0d exp=0/0", vcnt - v0, fcnt - f0); end
        checks++; if (data !== m_data) begin failures++; $display("FAIL ena_data got=%h exp=%h", data, m_data); end
        checks++; if (ready !== m_ready || overrun !== m_ovr)
            begin failures++; $display("FAIL ena_flags got=%b%b exp=%b%b", ready, overrun, m_ready, m_ovr); end
        b = 8'($urandom);
        tx(b, 1'b1, C, -1, -1, 1'b1); model_frame(b, 1'b0);
        in = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (data !== m_data) begin failures++; $display("FAIL ena_after_data got=%h exp=%h", data, m_data); end
        checks++; if (overrun !== m_ovr) begin failures++; $display("FAIL ena_after_overrun got=%b exp=%b", overrun, m_ovr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_dat[$];
        int         exp_start[$];
        int         base, f0, rd_off;
        logic [7:0] b;
        base = vq_dat.size();
        f0 = fcnt;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            rd_off = ($urandom_range(1, 0) == 1) ? 4 * C : -1;
            if (rd_off >= 0) model_rd();
            tx(b, 1'b1, (i == 9) ? C : H + 1, rd_off, -1, 1'b1);
            model_frame(b, 1'b0);
            exp_dat.push_back(b);
            exp_start.push_back(tx_start);
        end
        in = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (vq_dat.size() - base != 10)
            begin failures++; $display("FAIL b2b_count got=%0d exp=10", vq_dat.size() - base); end
        for (int i = 0; i < 10 && base + i < vq_dat.size(); i++) begin
            checks++; if (vq_dat[base+i] !== exp_dat[i])
                begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, vq_dat[base+i], exp_dat[i]); end
            checks++; if (vq_cyc[base+i] - exp_start[i] != LAT)
                begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, vq_cyc[base+i] - exp_start[i], LAT); end
        end
        checks++; if (ready !== m_ready || overrun !== m_ovr)
            begin failures++; $display("FAIL b2b_flags got=%b%b exp=%b%b", ready, overrun, m_ready, m_ovr); end
        checks++; if (fcnt != f0) begin failures++; $display("FAIL b2b_frame_err got=%0d exp=0", fcnt - f0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overrun();
        test_rd_same_cycle();
        test_reset_midframe();
        test_ena_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
